led_irq_ctrl: RTL and testbench

Register-and-interrupt stage wrapped around led_cnt. It drives led_cnt's divider configuration (div_o/wren_o) and consumes its interrupt output: led_int_i edges are counted, led_cnt is auto-cleared via int_clr_o, and events are coalesced into a single CPU interrupt irq_o. It sits between the CPU-side simple register bus and led_cnt, all in the 100 MHz domain.

---
 rtl/led_irq_pkg.sv | 22 ++
 rtl/led_irq_regs.sv | 118 +++++++++++
 rtl/led_irq_ctrl.sv | 157 +++++++++++++++
 tb/tb_led_irq_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_irq_pkg.sv
// Shared register map, FSM state type and STATUS field layout for the led_cnt interrupt stage.
// No logic and no latency; these are constants only.
package led_irq_pkg;

  localparam logic [2:0] ADDR_DIV     = 3'd0;
  localparam logic [2:0] ADDR_CTRL    = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_TIMEOUT = 3'd3;
  localparam logic [2:0] ADDR_STAMP   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_IRQ   = 2'd2
  } state_e;

  // STATUS layout: event count at [CNT_W-1:0], flags sit just above it at CNT_W + offset
  localparam int STATUS_CNT_LSB  = 0;
  localparam int STATUS_OVF_OFS  = 0;
  localparam int STATUS_PEND_OFS = 1;

endpackage

// File: rtl/led_irq_regs.sv
// Register file: DIV/CTRL/TIMEOUT storage, read mux, wren_o load strobe and STATUS ACK strobe.
// Reads return one cycle after rd_en_i (old value on same-cycle write); no backpressure, a strobe is always accepted.
module led_irq_regs
  import led_irq_pkg::*;
#(
  parameter int DIV_W = 5,
  parameter int CNT_W = 8,
  parameter int TO_W  = 16
) (
  input  logic             clk100,
  input  logic             rstn,
  input  logic             wr_en_i,
  input  logic [2:0]       wr_addr_i,
  input  logic [31:0]      wr_data_i,
  input  logic             rd_en_i,
  input  logic [2:0]       rd_addr_i,
  input  logic [CNT_W-1:0] evt_cnt_i,
  input  logic             ovf_i,
  input  logic             pend_i,
  input  logic [CNT_W-1:0] stamp_i,
  output logic [31:0]      rd_data_o,
  output logic             rd_valid_o,
  output logic [DIV_W-1:0] div_o,
  output logic             wren_o,
  output logic [CNT_W-1:0] thresh_o,
  output logic             irq_en_o,
  output logic             irq_en_nxt_o,
  output logic [TO_W-1:0]  timeout_o,
  output logic             ack_o
);

  logic [DIV_W-1:0] div_q, div_d;
  logic             wren_q, wren_d;
  logic [CNT_W-1:0] thresh_q, thresh_d;
  logic             irq_en_q, irq_en_d;
  logic [TO_W-1:0]  timeout_q, timeout_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic [31:0]      rd_word;
  logic             unused_wr_bits;

  assign unused_wr_bits = ^wr_data_i;

  always_comb begin
    div_d     = div_q;
    wren_d    = 1'b0;
    thresh_d  = thresh_q;
    irq_en_d  = irq_en_q;
    timeout_d = timeout_q;
    if (wr_en_i) begin
      case (wr_addr_i)
        ADDR_DIV: begin
          div_d  = wr_data_i[DIV_W-1:0];
          wren_d = 1'b1;
        end
        ADDR_CTRL: begin
          thresh_d = wr_data_i[CNT_W-1:0];
          irq_en_d = wr_data_i[CNT_W];
        end
        ADDR_TIMEOUT: timeout_d = wr_data_i[TO_W-1:0];
        default: ;
      endcase
    end
  end

  // Mux reads registered state only, so a coincident write is seen on the next read
  always_comb begin
    rd_word = '0;
    case (rd_addr_i)
      ADDR_DIV: rd_word[DIV_W-1:0] = div_q;
      ADDR_CTRL: begin
        rd_word[CNT_W-1:0] = thresh_q;
        rd_word[CNT_W]     = irq_en_q;
      end
      ADDR_STATUS: begin
        rd_word[STATUS_CNT_LSB +: CNT_W]     = evt_cnt_i;
        rd_word[CNT_W + STATUS_OVF_OFS]  = ovf_i;
        rd_word[CNT_W + STATUS_PEND_OFS] = pend_i;
      end
      ADDR_TIMEOUT: rd_word[TO_W-1:0] = timeout_q;
      ADDR_STAMP: rd_word[CNT_W-1:0] = stamp_i;
      default: ;
    endcase
    rd_data_d  = rd_en_i ? rd_word : rd_data_q;
    rd_valid_d = rd_en_i;
  end

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      div_q      <= DIV_W'(1);
      wren_q     <= 1'b0;
      thresh_q   <= CNT_W'(1);
      irq_en_q   <= 1'b0;
      timeout_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      wren_q     <= wren_d;
      thresh_q   <= thresh_d;
      irq_en_q   <= irq_en_d;
      timeout_q  <= timeout_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign ack_o        = wr_en_i && (wr_addr_i == ADDR_STATUS) && wr_data_i[0];
  assign rd_data_o    = rd_data_q;
  assign rd_valid_o   = rd_valid_q;
  assign div_o        = div_q;
  assign wren_o       = wren_q;
  assign thresh_o     = thresh_q;
  assign irq_en_o     = irq_en_q;
  assign irq_en_nxt_o = irq_en_d;
  assign timeout_o    = timeout_q;

endmodule

// File: rtl/led_irq_ctrl.sv
// led_cnt interrupt stage: edge-counts led_int_i, auto-clears led_cnt, coalesces into irq_o; LED_IRQ_STAMP_EN adds a STAMP register.
// int_clr_o one cycle after an edge, irq_o registered alongside the IRQ state; no backpressure.
module led_irq_ctrl
  import led_irq_pkg::*;
#(
  parameter int DIV_W = 5,
  parameter int CNT_W = 8,
  parameter int TO_W  = 16
) (
  input  logic             clk100,
  input  logic             rstn,
  input  logic             wr_en_i,
  input  logic [2:0]       wr_addr_i,
  input  logic [31:0]      wr_data_i,
  input  logic             rd_en_i,
  input  logic [2:0]       rd_addr_i,
  output logic [31:0]      rd_data_o,
  output logic             rd_valid_o,
  input  logic             led_int_i,
  input  logic [CNT_W-1:0] int_cnt_i,
  output logic [DIV_W-1:0] div_o,
  output logic             wren_o,
  output logic             int_clr_o,
  output logic             irq_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic             led_int_q, led_int_d;
  logic             int_clr_q, int_clr_d;
  logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic             ovf_q, ovf_d;
  logic [TO_W-1:0]  timer_q, timer_d;
  logic             irq_q, irq_d;
  logic             evt, new_win;
  logic [CNT_W-1:0] thr_eff, stamp;
  logic [CNT_W-1:0] thresh;
  logic             irq_en, irq_en_nxt, ack;
  logic [TO_W-1:0]  timeout;

  led_irq_regs #(.DIV_W(DIV_W), .CNT_W(CNT_W), .TO_W(TO_W)) u_regs (
    .clk100      (clk100),
    .rstn        (rstn),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .rd_en_i     (rd_en_i),
    .rd_addr_i   (rd_addr_i),
    .evt_cnt_i   (evt_cnt_q),
    .ovf_i       (ovf_q),
    .pend_i      (state_q == ST_IRQ),
    .stamp_i     (stamp),
    .rd_data_o   (rd_data_o),
    .rd_valid_o  (rd_valid_o),
    .div_o       (div_o),
    .wren_o      (wren_o),
    .thresh_o    (thresh),
    .irq_en_o    (irq_en),
    .irq_en_nxt_o(irq_en_nxt),
    .timeout_o   (timeout),
    .ack_o       (ack)
  );

  assign evt     = led_int_i & ~led_int_q;
  assign thr_eff = (thresh == '0) ? CNT_ONE : thresh;

  always_comb begin
    led_int_d = led_int_i;
    int_clr_d = evt;
    state_d   = state_q;
    evt_cnt_d = evt_cnt_q;
    ovf_d     = ovf_q;
    timer_d   = timer_q;
    new_win   = 1'b0;
    if (ack) begin
      // ACK from any state closes the window; a coincident edge opens the next one
      ovf_d   = 1'b0;
      timer_d = '0;
      if (evt) begin
        state_d   = ST_ACCUM;
        evt_cnt_d = CNT_ONE;
        new_win   = 1'b1;
      end else begin
        state_d   = ST_IDLE;
        evt_cnt_d = '0;
      end
    end else begin
      if (evt) begin
        if (evt_cnt_q == CNT_MAX) ovf_d = 1'b1;
        else                      evt_cnt_d = evt_cnt_q + CNT_ONE;
      end
      case (state_q)
        ST_IDLE: begin
          if (evt) begin
            state_d = ST_ACCUM;
            timer_d = '0;
            new_win = 1'b1;
          end
        end
        ST_ACCUM: begin
          timer_d = timer_q + 1'b1;
          if ((evt_cnt_d >= thr_eff) ||
              ((timeout != '0) && (timer_q == timeout - 1'b1)))
            state_d = ST_IRQ;
        end
        ST_IRQ: ;
        default: state_d = ST_IDLE;
      endcase
    end
    irq_d = (state_d == ST_IRQ) && irq_en_nxt;
  end

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      led_int_q <= 1'b0;
      int_clr_q <= 1'b0;
      evt_cnt_q <= '0;
      ovf_q     <= 1'b0;
      timer_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      led_int_q <= led_int_d;
      int_clr_q <= int_clr_d;
      evt_cnt_q <= evt_cnt_d;
      ovf_q     <= ovf_d;
      timer_q   <= timer_d;
      irq_q     <= irq_d;
    end
  end

`ifdef LED_IRQ_STAMP_EN
  logic [CNT_W-1:0] stamp_q, stamp_d;

  always_comb begin
    stamp_d = new_win ? int_cnt_i : stamp_q;
  end

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) stamp_q <= '0;
    else       stamp_q <= stamp_d;
  end

  assign stamp = stamp_q;
`else
  logic unused_stamp;
  assign unused_stamp = new_win ^ (^int_cnt_i) ^ irq_en;
  assign stamp        = '0;
`endif

  assign int_clr_o = int_clr_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_led_irq_ctrl.sv
// Directed + randomized bench for led_irq_ctrl; expectations come from the coalescing rules via plain arithmetic.
// Inputs are driven and outputs sampled 1 ns after each rising clock edge.
module tb_led_irq_ctrl;

  localparam int DIV_W = 5;
  localparam int CNT_W = 8;
  localparam int TO_W  = 16;

  logic             clk100 = 1'b0;
  logic             rstn;
  logic             wr_en_i;
  logic [2:0]       wr_addr_i;
  logic [31:0]      wr_data_i;
  logic             rd_en_i;
  logic [2:0]       rd_addr_i;
  logic [31:0]      rd_data_o;
  logic             rd_valid_o;
  logic             led_int_i;
  logic [CNT_W-1:0] int_cnt_i;
  logic [DIV_W-1:0] div_o;
  logic             wren_o;
  logic             int_clr_o;
  logic             irq_o;

  int n_chk  = 0;
  int n_fail = 0;
  int clr_seen  = 0;
  int wren_seen = 0;

  led_irq_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
    .clk100    (clk100),
    .rstn      (rstn),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .rd_en_i   (rd_en_i),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_data_o),
    .rd_valid_o(rd_valid_o),
    .led_int_i (led_int_i),
    .int_cnt_i (int_cnt_i),
    .div_o     (div_o),
    .wren_o    (wren_o),
    .int_clr_o (int_clr_o),
    .irq_o     (irq_o)
  );

  always #5 clk100 = ~clk100;

  always @(negedge clk100) begin
    if (int_clr_o) clr_seen++;
    if (wren_o)    wren_seen++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, observed no end, expected summary");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
    tick();
    wr_en_i = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    rd_en_i = 1'b1; rd_addr_i = a;
    tick();
    rd_en_i = 1'b0;
    chk({tag, "_vld"}, 32'(rd_valid_o), 32'd1);
    chk(tag, rd_data_o, exp);
  endtask

  task automatic pulse(input int gap);
    led_int_i = 1'b1;
    tick();
    led_int_i = 1'b0;
    tick();
    repeat (gap) tick();
  endtask

  // Reference: STATUS after n edges in one window, saturating count, overflow once past the maximum
  function automatic logic [31:0] exp_status(input int n_edges, input bit pend);
    int c;
    bit o;
    c = (n_edges > 255) ? 255 : n_edges;
    o = (n_edges > 255);
    return (32'(pend) << 9) | (32'(o) << 8) | 32'(c);
  endfunction

  initial begin
    int k, t, clr0;
    rstn = 1'b0; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    rd_en_i = 1'b0; rd_addr_i = '0; led_int_i = 1'b0; int_cnt_i = '0;
    repeat (3) tick();
    chk("rst_div", 32'(div_o), 32'd1);
    chk("rst_irq", 32'(irq_o), 32'd0);
    chk("rst_wren", 32'(wren_o), 32'd0);
    chk("rst_clr", 32'(int_clr_o), 32'd0);
    chk("rst_rdv", 32'(rd_valid_o), 32'd0);
    chk("rst_rdd", rd_data_o, 32'd0);
    rstn = 1'b1;
    repeat (5) tick();
    chk("idle_wren_cnt", 32'(wren_seen), 32'd0);
    rd_chk("rst_status", 3'd2, 32'd0);
    tick();
    chk("rdv_one_cycle", 32'(rd_valid_o), 32'd0);
    rd_chk("rst_ctrl", 3'd1, 32'h001);
    rd_chk("rst_timeout", 3'd3, 32'd0);

    // DIV writes and load strobes
    wr(3'd0, 32'h3);
    chk("div3", 32'(div_o), 32'd3);
    chk("wren_pulse", 32'(wren_o), 32'd1);
    tick();
    chk("wren_drop", 32'(wren_o), 32'd0);
    chk("wren_cnt1", 32'(wren_seen), 32'd1);
    rd_chk("rd_div", 3'd0, 32'd3);
    wr_en_i = 1'b1; wr_addr_i = 3'd0; wr_data_i = 32'h5;
    tick();
    chk("b2b_wren_a", 32'(wren_o), 32'd1);
    wr_data_i = 32'h7;
    tick();
    wr_en_i = 1'b0;
    chk("b2b_wren_b", 32'(wren_o), 32'd1);
    chk("b2b_div", 32'(div_o), 32'd7);
    tick();
    chk("wren_cnt3", 32'(wren_seen), 32'd3);
    wr_en_i = 1'b1; wr_addr_i = 3'd0; wr_data_i = 32'h9;
    rd_en_i = 1'b1; rd_addr_i = 3'd0;
    tick();
    wr_en_i = 1'b0; rd_en_i = 1'b0;
    chk("rw_same_old", rd_data_o, 32'd7);
    chk("rw_same_div", 32'(div_o), 32'd9);
    wr(3'd5, 32'hFFFF_FFFF);
    rd_chk("rd_addr5", 3'd5, 32'd0);
    rd_chk("rd_addr7", 3'd7, 32'd0);

    // Threshold 3 with exact irq timing on the third edge
    wr(3'd1, 32'h103);
    clr0 = clr_seen;
    pulse($urandom_range(0, 3));
    pulse($urandom_range(0, 3));
    chk("thr3_early", 32'(irq_o), 32'd0);
    led_int_i = 1'b1;
    tick();
    led_int_i = 1'b0;
    chk("thr3_irq", 32'(irq_o), 32'd1);
    tick();
    chk("thr3_clr", 32'(clr_seen - clr0), 32'd3);
    rd_chk("thr3_status", 3'd2, exp_status(3, 1'b1));
    wr(3'd2, 32'h1);
    chk("thr3_ack_irq", 32'(irq_o), 32'd0);
    rd_chk("thr3_ack_status", 3'd2, 32'd0);

    // Timeout: one edge, threshold out of reach
    wr(3'd1, 32'h10A);
    wr(3'd3, 32'd100);
    led_int_i = 1'b1;
    tick();
    led_int_i = 1'b0;
    k = 0;
    while (irq_o !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    chk("to_delay", 32'(k), 32'd100);
    rd_chk("to_status", 3'd2, exp_status(1, 1'b1));
    wr(3'd2, 32'h1);
    wr(3'd3, 32'd0);

    // Randomized thresholds
    for (int r = 0; r < 3; r++) begin
      t = $urandom_range(2, 12);
      wr(3'd1, 32'h100 | 32'(t));
      for (int e = 1; e <= t; e++) begin
        led_int_i = 1'b1;
        tick();
        led_int_i = 1'b0;
        chk("rnd_irq", 32'(irq_o), 32'(e >= t));
        tick();
        repeat ($urandom_range(0, 3)) tick();
      end
      rd_chk("rnd_status", 3'd2, exp_status(t, 1'b1));
      wr(3'd2, 32'h1);
      chk("rnd_ack_irq", 32'(irq_o), 32'd0);
    end

    // Threshold 0 behaves as 1
    wr(3'd1, 32'h100);
    led_int_i = 1'b1;
    tick();
    led_int_i = 1'b0;
    chk("thr0_accum", 32'(irq_o), 32'd0);
    tick();
    chk("thr0_irq", 32'(irq_o), 32'd1);
    rd_chk("thr0_status", 3'd2, exp_status(1, 1'b1));
    wr(3'd2, 32'h1);

    // Saturation, overflow, ACK coincident with an edge
    wr(3'd1, 32'h1FF);
    clr0 = clr_seen;
    for (int e = 0; e < 256; e++) pulse(0);
    chk("sat_clr", 32'(clr_seen - clr0), 32'd256);
    chk("sat_irq", 32'(irq_o), 32'd1);
    rd_chk("sat_status", 3'd2, exp_status(256, 1'b1));
    wr_en_i = 1'b1; wr_addr_i = 3'd2; wr_data_i = 32'h1; led_int_i = 1'b1;
    tick();
    wr_en_i = 1'b0; led_int_i = 1'b0;
    tick();
    chk("ackevt_irq", 32'(irq_o), 32'd0);
    rd_chk("ackevt_status", 3'd2, exp_status(1, 1'b0));
    wr(3'd2, 32'h1);
    rd_chk("ack_accum_status", 3'd2, 32'd0);

    // irq_en masks irq_o without touching pend
    wr(3'd1, 32'h002);
    pulse(1);
    pulse(1);
    chk("mask_irq", 32'(irq_o), 32'd0);
    rd_chk("mask_pend", 3'd2, exp_status(2, 1'b1));
    wr(3'd1, 32'h102);
    chk("unmask_irq", 32'(irq_o), 32'd1);
    wr(3'd1, 32'h002);
    chk("remask_irq", 32'(irq_o), 32'd0);
    rd_chk("remask_pend", 3'd2, exp_status(2, 1'b1));
    wr(3'd2, 32'h1);

    // STAMP captures int_cnt_i only at window start
    wr(3'd1, 32'h10A);
    int_cnt_i = 8'h2A;
    pulse(0);
    int_cnt_i = 8'h55;
    pulse(0);
`ifdef LED_IRQ_STAMP_EN
    rd_chk("stamp", 3'd4, 32'h2A);
`else
    rd_chk("stamp", 3'd4, 32'h0);
`endif
    wr(3'd2, 32'h1);

    // Reset in the middle of a window
    pulse(0);
    clr0 = clr_seen;
    led_int_i = 1'b1;
    #1;
    rstn = 1'b0;
    #2;
    chk("mid_rst_clr", 32'(int_clr_o), 32'd0);
    chk("mid_rst_wren", 32'(wren_o), 32'd0);
    chk("mid_rst_irq", 32'(irq_o), 32'd0);
    tick();
    led_int_i = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    chk("mid_rst_clr_cnt", 32'(clr_seen - clr0), 32'd0);
    chk("mid_rst_div", 32'(div_o), 32'd1);
    rd_chk("mid_rst_status", 3'd2, 32'd0);
    rd_chk("mid_rst_ctrl", 3'd1, 32'h001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
